// File: rtl/output_buffer_load_ctrl_if.sv
// Load/stream bundle between the output-buffer load controller and its neighbours.
// OUT_LOAD_TAG_EN adds the per-word group tag rtag_o.
interface output_buffer_load_ctrl_if;
  logic        start_i;
  logic [2:0]  before_load_mode_i;
  logic        load_en_o;
  logic [4:0]  load_cnt_o;
  logic [31:0] output_buffer_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        rready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
`ifdef OUT_LOAD_TAG_EN
  logic [4:0]  rtag_o;
`endif

  modport master (
`ifdef OUT_LOAD_TAG_EN
    output rtag_o,
`endif
    input  start_i, before_load_mode_i, output_buffer_i, rready_i,
    output load_en_o, load_cnt_o, rdata_o, rvalid_o, busy_o, done_o, err_o
  );

  modport slave (
`ifdef OUT_LOAD_TAG_EN
    input  rtag_o,
`endif
    output start_i, before_load_mode_i, output_buffer_i, rready_i,
    input  load_en_o, load_cnt_o, rdata_o, rvalid_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/output_buffer_load_ctrl.sv
// Pulls 1 or 32 words out of the PIM output buffer into a small FIFO and streams them
// to the bus. Optional feature macro: OUT_LOAD_TAG_EN (adds rtag_o group index per word).
module output_buffer_load_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output_buffer_load_ctrl_if.master    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [2:0] MODE_READ = 3'b011;
  localparam logic [2:0] MODE_PAR  = 3'b101;
  localparam logic [2:0] MODE_RBR  = 3'b110;
`ifdef OUT_LOAD_TAG_EN
  localparam int W = 37;
`else
  localparam int W = 32;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t        state;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [5:0]    words_left;
  logic [4:0]    load_cnt;
  logic          done_q, err_q;
  logic          push, pop, rvalid, mode_ok;
  logic [W-1:0]  wr_word, head;

  assign mode_ok = (bus.before_load_mode_i == MODE_READ) ||
                   (bus.before_load_mode_i == MODE_PAR)  ||
                   (bus.before_load_mode_i == MODE_RBR);
  // Request only on free space; a same-cycle pop does not open a slot for the request.
  assign push    = (state == LOAD) && (count != FULL);
  assign rvalid  = (count != '0);
  assign pop     = rvalid && bus.rready_i;
  assign head    = mem[rd_ptr];

`ifdef OUT_LOAD_TAG_EN
  logic is_read;
  // ~load_cnt is the group index (31 - load_cnt).
  assign wr_word    = {(is_read ? 5'd0 : ~load_cnt), bus.output_buffer_i};
  assign bus.rtag_o = rvalid ? head[36:32] : 5'd0;
`else
  assign wr_word    = bus.output_buffer_i;
`endif

  assign bus.load_en_o  = push;
  assign bus.load_cnt_o = load_cnt;
  assign bus.rdata_o    = rvalid ? head[31:0] : 32'd0;
  assign bus.rvalid_o   = rvalid;
  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      load_cnt   <= 5'd31;
      words_left <= 6'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
`ifdef OUT_LOAD_TAG_EN
      is_read    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      case (state)
        IDLE: begin
          load_cnt <= 5'd31;
          if (bus.start_i) begin
            if (mode_ok) begin
              state      <= LOAD;
              words_left <= (bus.before_load_mode_i == MODE_READ) ? 6'd1 : 6'd32;
`ifdef OUT_LOAD_TAG_EN
              is_read    <= (bus.before_load_mode_i == MODE_READ);
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (push) begin
            // Saturate at group 31 so the index never wraps back to 31 mid-sequence.
            if (load_cnt != 5'd0) load_cnt <= load_cnt - 1'b1;
            words_left <= words_left - 1'b1;
            if (words_left == 6'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && count == ONE) begin
            state    <= IDLE;
            done_q   <= 1'b1;
            load_cnt <= 5'd31;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_buffer_load_ctrl.sv
// Randomized scoreboard bench: expected words are queued at start, a negedge monitor
// pops them on every bus handshake and checks the cycle-level rules of the load stream.
module tb_output_buffer_load_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_buffer_load_ctrl_if bus();
  output_buffer_load_ctrl #(.FIFO_DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  logic [31:0] base = 32'd0;
  // Output buffer returns base ^ group, group = 31 - load_cnt.
  always_comb bus.output_buffer_i = base ^ {27'd0, ~bus.load_cnt_o};

  logic [31:0] exp_q[$];
`ifdef OUT_LOAD_TAG_EN
  logic [4:0]  tag_q[$];
`endif
  int occ = 0, loaded = 0, total = 0;
  bit exp_busy = 0, exp_done = 0, exp_err = 0, mon_on = 0;
  int errors = 0, checks = 0;
  int rr_mode = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: bus.rready_i = 1'b0;
      1: bus.rready_i = 1'b1;
      default: bus.rready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (mon_on) begin
      logic [4:0] ecnt;
      bit push, pop;
      ecnt = !exp_busy ? 5'd31 : (loaded >= 31) ? 5'd0 : 5'(31 - loaded);
      push = exp_busy && (loaded < total) && (occ < DEPTH);
      pop  = (occ != 0) && bus.rready_i;
      check("busy",     32'(bus.busy_o),   32'(exp_busy));
      check("done",     32'(bus.done_o),   32'(exp_done));
      check("err",      32'(bus.err_o),    32'(exp_err));
      check("rvalid",   32'(bus.rvalid_o), 32'(occ != 0));
      check("load_en",  32'(bus.load_en_o), 32'(push));
      check("load_cnt", 32'(bus.load_cnt_o), 32'(ecnt));
      if (occ == 0) check("rdata_empty", bus.rdata_o, 32'd0);
`ifdef OUT_LOAD_TAG_EN
      if (occ == 0) check("rtag_empty", 32'(bus.rtag_o), 32'd0);
`endif
      exp_done = 0;
      if (pop) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata: pop with empty scoreboard, got %h", bus.rdata_o);
        end else begin
          check("rdata", bus.rdata_o, exp_q.pop_front());
`ifdef OUT_LOAD_TAG_EN
          check("rtag", 32'(bus.rtag_o), 32'(tag_q.pop_front()));
`endif
        end
      end
      if (push) loaded++;
      occ = occ + int'(push) - int'(pop);
      if (pop && exp_busy && loaded == total && occ == 0) begin
        exp_busy = 0;
        exp_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
`ifdef OUT_LOAD_TAG_EN
    tag_q.delete();
`endif
    occ = 0; loaded = 0; total = 0;
    exp_busy = 0; exp_done = 0; exp_err = 0;
  endtask

  task automatic do_start(logic [2:0] mode, logic [31:0] b);
    bit good, acc;
    good = (mode == 3'b011) || (mode == 3'b101) || (mode == 3'b110);
    acc  = good && !exp_busy;
    if (acc) base = b;
    bus.start_i = 1'b1;
    bus.before_load_mode_i = mode;
    tick();
    bus.start_i = 1'b0;
    bus.before_load_mode_i = 3'($urandom);
    if (acc) begin
      total  = (mode == 3'b011) ? 1 : 32;
      loaded = 0;
      for (int g = 0; g < total; g++) begin
        exp_q.push_back(b ^ 32'(g));
`ifdef OUT_LOAD_TAG_EN
        tag_q.push_back((mode == 3'b011) ? 5'd0 : 5'(g));
`endif
      end
      exp_busy = 1;
    end else if (!good && !exp_busy) begin
      exp_err = 1;
      tick();
      exp_err = 0;
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (exp_busy && n < 3000) begin tick(); n++; end
    checks++;
    if (exp_busy) begin
      errors++;
      $display("FAIL %s: sequence still busy after %0d cycles, loaded=%0d of %0d", name, n, loaded, total);
      do_reset();
    end
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.before_load_mode_i = 3'd0;
    bus.rready_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    mon_on = 1;
    repeat (2) tick();

    // Full PARALLEL at full throughput
    rr_mode = 1;
    do_start(3'b101, 32'hA000_0000);
    wait_idle("parallel");

    // Single READ word
    do_start(3'b011, 32'hDEAD_BEEF);
    wait_idle("read");

    // RBR with back-pressure: stall at FIFO full, then resume
    rr_mode = 0;
    do_start(3'b110, 32'h5A5A_0000);
    repeat (8) tick();
    check("stall_cnt", 32'(bus.load_cnt_o), 32'd27);
    check("stall_en",  32'(bus.load_en_o),  32'd0);
    rr_mode = 2;
    wait_idle("rbr_backpressure");

    // Unsupported mode
    do_start(3'b001, 32'h0);
    repeat (2) tick();

    // Reset in the middle of a load
    rr_mode = 1;
    do_start(3'b101, 32'h1234_5600);
    for (int n = 0; n < 100 && loaded < 10; n++) tick();
    check("mid_reset_reach", 32'(loaded >= 10), 32'd1);
    do_reset();
    repeat (2) tick();
    do_start(3'b101, 32'hC0DE_0000);
    wait_idle("after_reset");

    // Re-pulse of start during LOAD is ignored
    do_start(3'b101, 32'hB000_0000);
    repeat (5) tick();
    do_start(3'b110, 32'hFFFF_FFFF);
    do_start(3'b010, 32'h0);
    wait_idle("repulse");

    for (int i = 0; i < 25; i++) begin
      logic [2:0] m;
      case ($urandom_range(0, 3))
        0: m = 3'b011;
        1: m = 3'b101;
        2: m = 3'b110;
        default: m = 3'($urandom);
      endcase
      rr_mode = $urandom_range(1, 2);
      do_start(m, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) tick();
        do_start(3'($urandom), $urandom);
      end
      wait_idle("random");
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
